// File: rtl/risc8_pkg.sv
// Shared constants for the RISC-8 decode stage: opcodes, ALU selects,
// instruction field positions and default widths.
package risc8_pkg;

    localparam int DW_DEF = 8;
    localparam int IW_DEF = 16;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_LDI = 4'b0100;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // ALU select codes
    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0001;
    localparam logic [3:0] SEL_AND = 4'b0010;
    localparam logic [3:0] SEL_OR  = 4'b0011;

    // Field bit positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // True for the register-register ALU opcodes
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // ALU select for a register-register opcode
    function automatic logic [3:0] alu_sel(input logic [3:0] op);
        logic [3:0] sel;
        case (op)
            OP_SUB:  sel = SEL_SUB;
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            default: sel = SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/risc8_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous
// write port. r0 is never written and always reads zero.
module risc8_regfile
    import risc8_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREG)-1:0]  ra1,
    input  logic [$clog2(NREG)-1:0]  ra2,
    output logic [DW-1:0]            rd1,
    output logic [DW-1:0]            rd2,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  wa,
    input  logic [DW-1:0]            wd
);

    logic [DW-1:0] mem [NREG];

    // Clear everything on reset; otherwise write any register except r0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/id_stage.sv
// RISC-8 decode / operand-fetch stage. Decodes 16-bit instructions, reads
// operands with write-back bypass, and registers a/b/sel/rd for the ALU.
// Optional build macro ID_FWD_EN: forward the EX result into operand fetch
// instead of stalling one cycle on a read-after-write dependency.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. instr_valid must not depend on instr_ready; instr_ready may
// depend combinationally on the presented instruction (hazard check).
// The EX registers advance when ex_ready || !ex_valid.
module id_stage
    import risc8_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int IW   = IW_DEF,
    parameter int NREG = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    input  logic [IW-1:0]            instr,
    output logic                     instr_ready,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DW-1:0]            ex_a,
    output logic [DW-1:0]            ex_b,
    output logic [3:0]               ex_sel,
    output logic [$clog2(NREG)-1:0]  ex_rd,
    output logic                     ex_we,
    input  logic [DW-1:0]            ex_fwd_data,
    input  logic                     wb_we,
    input  logic [$clog2(NREG)-1:0]  wb_rd,
    input  logic [DW-1:0]            wb_data,
    output logic                     illegal
);

    localparam int AW = $clog2(NREG);

`ifdef ID_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Decoded fields
    logic [3:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [7:0]    imm;
    logic          is_alu, is_ldi, is_nop, is_bad;

    assign op     = instr[OP_MSB:OP_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs1    = instr[RS1_MSB:RS1_LSB];
    assign rs2    = instr[RS2_MSB:RS2_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];
    assign is_alu = is_alu_op(op);
    assign is_ldi = (op == OP_LDI);
    assign is_nop = (op == OP_NOP);
    assign is_bad = !(is_alu || is_ldi || is_nop);

    // Register file
    logic [DW-1:0] rf_d1, rf_d2;

    risc8_regfile #(.DW(DW), .NREG(NREG)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rf_d1),
        .rd2   (rf_d2),
        .we    (wb_we),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    // Match terms; r0 never matches so it always reads zero
    logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;

    assign ex_hit1 = ex_valid && ex_we && (ex_rd == rs1) && (rs1 != '0);
    assign ex_hit2 = ex_valid && ex_we && (ex_rd == rs2) && (rs2 != '0);
    assign wb_hit1 = wb_we && (wb_rd == rs1) && (rs1 != '0);
    assign wb_hit2 = wb_we && (wb_rd == rs2) && (rs2 != '0);

    // Operand select: EX forward (younger) beats WB bypass beats register file
    logic [DW-1:0] op_a, op_b;

    always_comb begin
        op_a = rf_d1;
        op_b = rf_d2;
        if (FWD_EN && ex_hit1) op_a = ex_fwd_data;
        else if (wb_hit1)      op_a = wb_data;
        if (FWD_EN && ex_hit2) op_b = ex_fwd_data;
        else if (wb_hit2)      op_b = wb_data;
    end

    // Without forwarding, an ALU op reading the EX destination waits one cycle
    logic hazard, load, accept;

    assign hazard      = !FWD_EN && is_alu && (ex_hit1 || ex_hit2);
    assign load        = ex_ready || !ex_valid;
    assign instr_ready = rst_n && load && !hazard;
    assign accept      = instr_valid && instr_ready;

    // EX stage registers: load a decoded op or a bubble, hold under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_sel   <= '0;
            ex_rd    <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal <= accept && is_bad;
            if (load) begin
                if (accept && (is_alu || is_ldi)) begin
                    ex_valid <= 1'b1;
                    ex_we    <= 1'b1;
                    ex_a     <= is_ldi ? '0 : op_a;
                    ex_b     <= is_ldi ? DW'(imm) : op_b;
                    ex_sel   <= is_ldi ? SEL_ADD : alu_sel(op);
                    ex_rd    <= rd;
                end else begin
                    ex_valid <= 1'b0;
                    ex_we    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage. A small ALU + one-cycle WB
// model closes the loop; expectations are hand-computed constants.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  ex_a, ex_b;
    logic [3:0]  ex_sel;
    logic [2:0]  ex_rd;
    logic        ex_we;
    logic [7:0]  ex_fwd_data;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    id_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_a        (ex_a),
        .ex_b        (ex_b),
        .ex_sel      (ex_sel),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_fwd_data (ex_fwd_data),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal)
    );

    // ---------------- ALU + write-back model ----------------
    logic [7:0] alu_y;
    logic       auto_wb;
    logic       m_wb_we, man_wb_we;
    logic [2:0] m_wb_rd, man_wb_rd;
    logic [7:0] m_wb_data, man_wb_data;

    always_comb begin
        alu_y = 8'h00;
        case (ex_sel)
            4'b0000: alu_y = ex_a + ex_b;
            4'b0001: alu_y = ex_a - ex_b;
            4'b0010: alu_y = ex_a & ex_b;
            4'b0011: alu_y = ex_a | ex_b;
            default: alu_y = 8'h00;
        endcase
    end

    assign ex_fwd_data = alu_y;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wb_we   <= 1'b0;
            m_wb_rd   <= 3'd0;
            m_wb_data <= 8'h00;
        end else begin
            m_wb_we   <= ex_valid && ex_ready && ex_we;
            m_wb_rd   <= ex_rd;
            m_wb_data <= alu_y;
        end
    end

    assign wb_we   = auto_wb ? m_wb_we   : man_wb_we;
    assign wb_rd   = auto_wb ? m_wb_rd   : man_wb_rd;
    assign wb_data = auto_wb ? m_wb_data : man_wb_data;

    // ---------------- encoders ----------------
    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'b0100, rd, 1'b0, imm};
    endfunction

    // ---------------- driver ----------------
    // Present an instruction until accepted; returns with EX showing its effect.
    task automatic send(input logic [15:0] w, output int stalls);
        bit done;
        stalls = 0;
        done = 0;
        instr_valid = 1'b1;
        instr = w;
        while (!done) begin
            @(negedge clk);
            if (instr_ready) begin
                done = 1;
            end else begin
                stalls++;
                if (stalls > 20) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout instr=%h not accepted within 20 cycles", w);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int s;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", instr_ready); end
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid got %b exp 0", ex_valid); end
        n_checks++; if (ex_we !== 1'b0) begin n_fail++; $display("FAIL rst_ex_we got %b exp 0", ex_we); end
        n_checks++; if ({ex_a, ex_b, ex_sel, ex_rd} !== 23'd0) begin n_fail++; $display("FAIL rst_ex_fields got a=%h b=%h sel=%h rd=%h exp 0", ex_a, ex_b, ex_sel, ex_rd); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got %b exp 0", illegal); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b exp 1", instr_ready); end
        for (int k = 0; k < 4; k++) begin
            logic [2:0] ra, rb;
            ra = 3'(2 * k + 1);
            rb = (k == 3) ? 3'd1 : 3'(2 * k + 2);
            send(enc_r(4'b0000, 3'd0, ra, rb), s);
            n_checks++; if (ex_a !== 8'h00 || ex_b !== 8'h00) begin n_fail++; $display("FAIL rst_regs r%0d=%h r%0d=%h exp 00", ra, ex_a, rb, ex_b); end
        end
    endtask

    task automatic test_ldi_add();
        int s, exp_st;
`ifdef ID_FWD_EN
        exp_st = 0;
`else
        exp_st = 1;
`endif
        send(enc_ldi(3'd1, 8'h05), s);
        n_checks++; if (ex_valid !== 1'b1 || ex_we !== 1'b1 || ex_a !== 8'h00 || ex_b !== 8'h05 || ex_sel !== 4'h0 || ex_rd !== 3'd1)
            begin n_fail++; $display("FAIL ldi_r1 got v=%b we=%b a=%h b=%h sel=%h rd=%0d exp 1 1 00 05 0 1", ex_valid, ex_we, ex_a, ex_b, ex_sel, ex_rd); end
        send(enc_ldi(3'd2, 8'hFB), s);
        n_checks++; if (s !== 0) begin n_fail++; $display("FAIL ldi_no_stall got %0d stalls exp 0", s); end
        send(enc_r(4'b0000, 3'd3, 3'd1, 3'd2), s);
        n_checks++; if (s !== exp_st) begin n_fail++; $display("FAIL add_stalls got %0d exp %0d", s, exp_st); end
        n_checks++; if (ex_valid !== 1'b1 || ex_a !== 8'h05 || ex_b !== 8'hFB || ex_sel !== 4'h0 || ex_rd !== 3'd3)
            begin n_fail++; $display("FAIL add_operands got v=%b a=%h b=%h sel=%h rd=%0d exp 1 05 FB 0 3", ex_valid, ex_a, ex_b, ex_sel, ex_rd); end
    endtask

    task automatic test_r0();
        int s;
        send(enc_ldi(3'd0, 8'hAA), s);
        send(enc_r(4'b0011, 3'd4, 3'd0, 3'd0), s);
        n_checks++; if (s !== 0) begin n_fail++; $display("FAIL r0_stall got %0d exp 0", s); end
        n_checks++; if (ex_a !== 8'h00 || ex_b !== 8'h00 || ex_sel !== 4'h3 || ex_rd !== 3'd4)
            begin n_fail++; $display("FAIL r0_read got a=%h b=%h sel=%h rd=%0d exp 00 00 3 4", ex_a, ex_b, ex_sel, ex_rd); end
    endtask

    task automatic test_backpressure();
        int s;
        send(enc_r(4'b0001, 3'd5, 3'd1, 3'd2), s);
        n_checks++; if (ex_a !== 8'h05 || ex_b !== 8'hFB || ex_sel !== 4'h1)
            begin n_fail++; $display("FAIL sub_issue got a=%h b=%h sel=%h exp 05 FB 1", ex_a, ex_b, ex_sel); end
        ex_ready = 1'b0;
        instr_valid = 1'b1;
        instr = enc_ldi(3'd7, 8'h11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d got %b exp 0", i, instr_ready); end
            n_checks++; if (ex_valid !== 1'b1 || ex_a !== 8'h05 || ex_b !== 8'hFB || ex_sel !== 4'h1 || ex_rd !== 3'd5)
                begin n_fail++; $display("FAIL bp_hold cycle %0d got v=%b a=%h b=%h sel=%h rd=%0d exp 1 05 FB 1 5", i, ex_valid, ex_a, ex_b, ex_sel, ex_rd); end
            @(posedge clk);
            #1;
            if (i == 0) begin
                auto_wb = 1'b0; man_wb_we = 1'b1; man_wb_rd = 3'd6; man_wb_data = 8'h99;
            end else if (i == 1) begin
                man_wb_we = 1'b0; auto_wb = 1'b1;
            end else begin
                ex_ready = 1'b1;
            end
        end
        @(negedge clk);
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", instr_ready); end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        n_checks++; if (ex_valid !== 1'b1 || ex_a !== 8'h00 || ex_b !== 8'h11 || ex_rd !== 3'd7)
            begin n_fail++; $display("FAIL bp_next got v=%b a=%h b=%h rd=%0d exp 1 00 11 7", ex_valid, ex_a, ex_b, ex_rd); end
    endtask

    task automatic test_illegal();
        int s;
        send(16'h7E00, s);
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse got %b exp 1", illegal); end
        n_checks++; if (ex_valid !== 1'b0 || ex_we !== 1'b0) begin n_fail++; $display("FAIL illegal_bubble got v=%b we=%b exp 0 0", ex_valid, ex_we); end
        n_checks++; if (ex_b !== 8'h11 || ex_rd !== 3'd7) begin n_fail++; $display("FAIL illegal_hold got b=%h rd=%0d exp 11 7", ex_b, ex_rd); end
        send(enc_r(4'b0000, 3'd0, 3'd7, 3'd6), s);
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle got %b exp 0", illegal); end
        n_checks++; if (ex_valid !== 1'b1 || ex_a !== 8'h11 || ex_b !== 8'h99)
            begin n_fail++; $display("FAIL illegal_rf got v=%b r7=%h r6=%h exp 1 11 99", ex_valid, ex_a, ex_b); end
    endtask

    task automatic test_nop();
        int s;
        send(16'hF000, s);
        n_checks++; if (ex_valid !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL nop got v=%b illegal=%b exp 0 0", ex_valid, illegal); end
    endtask

    task automatic test_wb_same_cycle();
        int s;
        auto_wb = 1'b0;
        man_wb_we = 1'b1; man_wb_rd = 3'd5; man_wb_data = 8'h3C;
        send(enc_r(4'b0010, 3'd6, 3'd5, 3'd5), s);
        man_wb_we = 1'b0;
        auto_wb = 1'b1;
        n_checks++; if (ex_a !== 8'h3C || ex_b !== 8'h3C || ex_sel !== 4'h2 || ex_rd !== 3'd6)
            begin n_fail++; $display("FAIL wb_through got a=%h b=%h sel=%h rd=%0d exp 3C 3C 2 6", ex_a, ex_b, ex_sel, ex_rd); end
    endtask

    task automatic test_reset_mid_bp();
        int s;
        send(enc_ldi(3'd3, 8'h42), s);
        ex_ready = 1'b0;
        n_checks++; if (ex_valid !== 1'b1 || ex_b !== 8'h42) begin n_fail++; $display("FAIL mid_bp_load got v=%b b=%h exp 1 42", ex_valid, ex_b); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (ex_valid !== 1'b0 || ex_b !== 8'h00 || ex_rd !== 3'd0 || instr_ready !== 1'b0)
            begin n_fail++; $display("FAIL mid_bp_reset got v=%b b=%h rd=%0d rdy=%b exp 0 00 0 0", ex_valid, ex_b, ex_rd, instr_ready); end
        rst_n = 1'b1;
        ex_ready = 1'b1;
        send(enc_r(4'b0000, 3'd0, 3'd5, 3'd6), s);
        n_checks++; if (ex_a !== 8'h00 || ex_b !== 8'h00) begin n_fail++; $display("FAIL mid_bp_rf_clear got r5=%h r6=%h exp 00 00", ex_a, ex_b); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        ex_ready = 1'b1;
        auto_wb = 1'b1;
        man_wb_we = 1'b0;
        man_wb_rd = 3'd0;
        man_wb_data = 8'h00;
        test_reset();
        test_ldi_add();
        test_r0();
        test_backpressure();
        test_illegal();
        test_nop();
        test_wb_same_cycle();
        test_reset_mid_bp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode/operand-fetch stage of the RISC-8 pipeline, directly upstream of the combinational 8-bit ALU. Accepts 16-bit instructions and decodes them. Reads two operands from an internal 8x8 register file, with write-back bypass and optional forwarding of the ALU result. Registers `a`, `b`, `sel` and destination info for the execute stage.

## Interface
Parameters:
- `DW`, 8, datapath width
- `IW`, 16, instruction width
- `NREG`, 8, register count (address width `$clog2(NREG)` = 3)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `instr_valid`  in  1  fetch presents an instruction
- `instr`  in  IW  instruction word
- `instr_ready`  out  1  instruction accepted when `instr_valid && instr_ready`
- `ex_valid`  out  1  EX registers hold a live instruction
- `ex_ready`  in  1  EX/WB can take the current EX instruction
- `ex_a`  out  DW  ALU operand a
- `ex_b`  out  DW  ALU operand b
- `ex_sel`  out  4  ALU select
- `ex_rd`  out  3  destination register
- `ex_we`  out  1  result is written back
- `ex_fwd_data`  in  DW  ALU result `y` for the instruction currently in EX
- `wb_we`  in  1  write-back enable
- `wb_rd`  in  3  write-back register
- `wb_data`  in  DW  write-back data
- `illegal`  out  1  one-cycle pulse: accepted instruction had an undefined opcode

## Operation
- Fields: `[15:12]` opcode, `[11:9]` rd, `[8:6]` rs1, `[5:3]` rs2, `[7:0]` imm8 (LDI only).
- Opcodes:
  - 0000 ADD: sel 0000
  - 0001 SUB: sel 0001
  - 0010 AND: sel 0010
  - 0011 OR: sel 0011
  - For all four: a = R[rs1], b = R[rs2], `ex_we` = 1.
  - 0100 LDI: sel 0000, a = 0, b = imm8, `ex_we` = 1.
  - 1111 NOP: inserts a bubble.
  - Any other opcode: bubble and `illegal` pulse.
- r0 reads as 0. Writes to r0 are ignored, and r0 is never a forwarding match.
- Operand source priority, per operand, for rs != 0:
  1. EX forward: `ex_valid && ex_we && ex_rd == rs` selects `ex_fwd_data` (only when `ID_FWD_EN` is defined).
  2. WB bypass: `wb_we && wb_rd == rs` selects `wb_data`.
  3. Register file.
- Register file write: on `wb_we && wb_rd != 0` at the clock edge.
- Stage-register update rule:
  - If `ex_ready || !ex_valid`, the EX registers load the decoded instruction, or a bubble if none is accepted.
  - Otherwise the EX registers hold all values.
- `instr_ready = rst_n && (ex_ready || !ex_valid) && !hazard`.
- Bubble: `ex_valid` = 0, `ex_we` = 0; `ex_a`, `ex_b`, `ex_sel`, `ex_rd` hold their previous values.

## Timing
- Reset (`rst_n` low at an edge):
  - All register file entries, `ex_a`, `ex_b`, `ex_sel`, `ex_rd` become 0.
  - `ex_valid`, `ex_we` and `illegal` become 0.
  - `instr_ready` is 0 while `rst_n` is low.
  - Reset mid-stall or mid-backpressure discards the in-flight instruction.
- Latency: instruction accepted at edge N is presented on `ex_*` after edge N, i.e. 1 cycle.
- `illegal` is asserted for the cycle after acceptance only.
- Write-back in the same cycle as a read of the same register returns the new data (write-through).
- Backpressure (`ex_valid && !ex_ready`):
  - EX outputs stay stable.
  - `instr_ready` = 0.
  - The register file still accepts write-back.
- Simultaneous write-back to rd and a read of rd while the EX instruction also targets rd: EX forwarding wins (younger result).

## Configuration
- `ID_FWD_EN` defined:
  - EX-to-ID forwarding is active.
  - `hazard` = 0; back-to-back dependent instructions issue every cycle.
- `ID_FWD_EN` undefined:
  - No EX forwarding.
  - `hazard` = 1 when an instruction that reads rs (rs != 0) matches `ex_rd` with `ex_valid && ex_we`. LDI and NOP read nothing.
  - `instr_ready` drops for exactly one cycle and a bubble is inserted. The dependent instruction then reads the value via WB bypass.

## Structure
- Package `risc8_pkg`:
  - Opcode constants and ALU select constants (ADD/SUB/AND/OR).
  - Field bit positions, and `DW`/`IW` defaults.
- Sub-module `risc8_regfile`:
  - NREG x DW, two async read ports, one sync write port.
  - r0 held at zero; synchronous active-low reset.
- Decode, forwarding mux, hazard logic and EX registers stay in `id_stage`.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles, then release. Expect all `ex_*` = 0, `ex_valid` = 0, `instr_ready` = 0 during reset and 1 after; r1..r7 read 0.
- LDI then ADD: LDI r1,0x05, LDI r2,0xFB, then ADD r3,r1,r2, with WB modelled 1 cycle after EX (`wb_data` = `ex_fwd_data` of the previous cycle).
  - `ID_FWD_EN` defined: ADD issues without stalls; `ex_a` = 0x05, `ex_b` = 0xFB, `ex_sel` = 0000.
  - `ID_FWD_EN` undefined: one bubble cycle, same operands.
- r0 discipline: LDI r0,0xAA, then OR r4,r0,r0. Expect `ex_a` = `ex_b` = 0x00, no forwarding, no stall.
- Backpressure: hold `ex_ready` = 0 for 3 cycles with SUB pending. Expect `ex_*` stable, `instr_ready` = 0, next instruction accepted on the cycle `ex_ready` returns to 1.
- Illegal opcode 0x7xxx: expect `illegal` = 1 for one cycle, `ex_valid` = 0, register file unchanged.
- Same-cycle write-back: `wb_we` = 1, `wb_rd` = 5, `wb_data` = 0x3C, while AND r6,r5,r5 is accepted. Expect `ex_a` = `ex_b` = 0x3C.
